// File: rtl/mul_seq_pkg.sv
// Shared constants and enums for the multiplier job sequencer.
// Holds peripheral register addresses, job FSM states and bus phases.
package mul_seq_pkg;

  localparam logic [15:0] ADDR_A1 = 16'h108;
  localparam logic [15:0] ADDR_A2 = 16'h110;
  localparam logic [15:0] ADDR_W  = 16'h118;
  localparam logic [15:0] ADDR_L  = 16'h120;
  localparam logic [15:0] ADDR_B  = 16'h128;

  typedef enum logic [2:0] {
    IDLE,
    WR_A,
    WR_B,
    POLL,
    RD_W,
    RD_L,
    RESP
  } state_t;

  typedef enum logic [1:0] {
    SETUP,
    STB,
    CAP
  } phase_t;

endpackage

// File: rtl/mul_job_sequencer_bus_txn.sv
// Single gpioemu bus transaction engine.
// Write: SETUP, STB. Read: SETUP, STB, CAP.
module bus_txn (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_read,
  input  logic [15:0] addr,
  input  logic [31:0] wdata,
  output logic        done,
  output logic [31:0] rdata,
  output logic [15:0] m_saddress,
  output logic        m_swr,
  output logic        m_srd,
  output logic [31:0] m_sdata_in,
  input  logic [31:0] m_sdata_out
);
  import mul_seq_pkg::*;

  phase_t phase;
  phase_t phase_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) phase <= SETUP;
    else        phase <= phase_nx;
  end

  // Strobes decode from the registered phase, so reset drops them at once.
  always_comb begin
    phase_nx   = phase;
    done       = 1'b0;
    m_swr      = 1'b0;
    m_srd      = 1'b0;
    m_saddress = start ? addr : 16'h0000;
    m_sdata_in = start ? wdata : 32'h0;
    rdata      = m_sdata_out;
    if (start) begin
      unique case (phase)
        SETUP: phase_nx = STB;
        STB: begin
          m_swr = !is_read;
          m_srd = is_read;
          if (is_read) begin
            phase_nx = CAP;
          end else begin
            done     = 1'b1;
            phase_nx = SETUP;
          end
        end
        CAP: begin
          done     = 1'b1;
          phase_nx = SETUP;
        end
        default: phase_nx = SETUP;
      endcase
    end
  end

endmodule

// File: rtl/mul_job_sequencer.sv
// Two-requester job sequencer driving the gpioemu multiplier bus.
// Optional poll timeout enabled with `define POLL_TIMEOUT_EN.
module mul_job_sequencer #(
  parameter int OPERAND_W  = 24,
  parameter int POLL_LIMIT = 255
) (
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [OPERAND_W-1:0] req0_a,
  input  logic [OPERAND_W-1:0] req0_b,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [OPERAND_W-1:0] req1_a,
  input  logic [OPERAND_W-1:0] req1_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [31:0]          rsp_w,
  output logic [31:0]          rsp_l,
  output logic                 rsp_err,
  output logic [15:0]          m_saddress,
  output logic                 m_swr,
  output logic                 m_srd,
  output logic [31:0]          m_sdata_in,
  input  logic [31:0]          m_sdata_out,
  output logic                 busy
);
  import mul_seq_pkg::*;

  state_t                state;
  logic [OPERAND_W-1:0]  a_q;
  logic [OPERAND_W-1:0]  b_q;
  logic                  id_q;
  logic                  last_grant;
  logic [31:0]           w_q;
  logic [31:0]           l_q;
  logic                  start;
  logic                  is_read;
  logic [15:0]           addr;
  logic [31:0]           wdata;
  logic                  done;
  logic [31:0]           rdata;
  logic                  idle;
  logic                  expire;
  logic                  poll_busy;

  assign idle       = (state == IDLE);
  assign req0_ready = idle & req0_valid & (!req1_valid | last_grant);
  assign req1_ready = idle & req1_valid & (!req0_valid | !last_grant);
  assign rsp_valid  = (state == RESP);
  assign rsp_id     = id_q;
  assign rsp_w      = w_q;
  assign rsp_l      = l_q;
  assign busy       = !idle;
  assign poll_busy  = (state == POLL) & done & (rdata != 32'h0);

  always_comb begin
    start   = 1'b1;
    is_read = 1'b0;
    addr    = 16'h0000;
    wdata   = 32'h0;
    unique case (state)
      WR_A: begin addr = ADDR_A1; wdata = 32'(a_q); end
      WR_B: begin addr = ADDR_A2; wdata = 32'(b_q); end
      POLL: begin addr = ADDR_B; is_read = 1'b1; end
      RD_W: begin addr = ADDR_W; is_read = 1'b1; end
      RD_L: begin addr = ADDR_L; is_read = 1'b1; end
      default: start = 1'b0;
    endcase
  end

`ifdef POLL_TIMEOUT_EN
  localparam logic [7:0] LIMIT = 8'(POLL_LIMIT);
  logic [7:0] polls;
  logic       err_q;

  assign expire  = (polls + 8'd1) >= LIMIT;
  assign rsp_err = err_q;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      polls <= 8'd0;
      err_q <= 1'b0;
    end else begin
      if (state == WR_A)  polls <= 8'd0;
      else if (poll_busy) polls <= polls + 8'd1;
      if (req0_ready | req1_ready) err_q <= 1'b0;
      else if (poll_busy & expire) err_q <= 1'b1;
    end
  end
`else
  assign expire  = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state      <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= 1'b0;
      last_grant <= 1'b1;
      w_q        <= 32'h0;
      l_q        <= 32'h0;
    end else begin
      unique case (state)
        IDLE: if (req0_ready | req1_ready) begin
          state      <= WR_A;
          id_q       <= req1_ready;
          last_grant <= req1_ready;
          a_q        <= req1_ready ? req1_a : req0_a;
          b_q        <= req1_ready ? req1_b : req0_b;
        end
        WR_A: if (done) state <= WR_B;
        WR_B: if (done) state <= POLL;
        POLL: if (done) begin
          if (rdata == 32'h0) begin
            state <= RD_W;
          end else if (expire) begin
            state <= RESP;
            w_q   <= 32'h0;
            l_q   <= 32'h0;
          end
        end
        RD_W: if (done) begin
          w_q   <= rdata;
          state <= RD_L;
        end
        RD_L: if (done) begin
          l_q   <= rdata;
          state <= RESP;
        end
        RESP: if (rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  bus_txn u_bus (
    .clk         (clk),
    .rst_n       (n_reset),
    .start       (start),
    .is_read     (is_read),
    .addr        (addr),
    .wdata       (wdata),
    .done        (done),
    .rdata       (rdata),
    .m_saddress  (m_saddress),
    .m_swr       (m_swr),
    .m_srd       (m_srd),
    .m_sdata_in  (m_sdata_in),
    .m_sdata_out (m_sdata_out)
  );

endmodule

// File: tb/tb_mul_job_sequencer.sv
// Directed bench for mul_job_sequencer with a gpioemu slave model.
// Covers the POLL_TIMEOUT_EN case when that macro is defined.
module tb_mul_job_sequencer;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [23:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        rsp_valid, rsp_id, rsp_err;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_w, rsp_l;
  logic [15:0] m_saddress;
  logic        m_swr, m_srd, busy;
  logic [31:0] m_sdata_in;
  logic [31:0] m_sdata_out = 32'h0;

  mul_job_sequencer #(.OPERAND_W(24), .POLL_LIMIT(4)) dut (
    .clk(clk), .n_reset(n_reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_w(rsp_w), .rsp_l(rsp_l), .rsp_err(rsp_err),
    .m_saddress(m_saddress), .m_swr(m_swr), .m_srd(m_srd),
    .m_sdata_in(m_sdata_in), .m_sdata_out(m_sdata_out), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [31:0] data;
  } op_t;

  typedef struct {
    logic        id;
    logic [31:0] w;
    logic [31:0] l;
    logic        err;
  } exp_t;

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;
  int viol = 0;
  int busy_left = 0;
  bit stuck = 0;
  bit timeout_mode = 0;
  op_t  trace[$];
  exp_t sb[$];
  int   grant_q[$];
  int   gcyc_q[$];
  logic [31:0] ra = 0, rb = 0;
  logic [15:0] prev_addr = 0;
  logic [31:0] prev_data = 0;
  logic        prev_stb = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Slave model, protocol monitor and scoreboard, all sampled mid-cycle.
  always @(negedge clk) begin
    logic [31:0] v;
    logic [63:0] p;
    exp_t e;
    #2;
    if (m_swr) begin
      trace.push_back('{1'b1, m_saddress, m_sdata_in});
      if (m_saddress == 16'h108) ra = m_sdata_in;
      else if (m_saddress == 16'h110) rb = m_sdata_in;
    end
    if (m_srd) begin
      p = 64'(ra) * 64'(rb);
      case (m_saddress)
        16'h128: begin
          v = (stuck || busy_left > 0) ? 32'h1 : 32'h0;
          if (busy_left > 0) busy_left--;
        end
        16'h118: v = p[31:0];
        16'h120: v = p[63:32];
        default: v = 32'hDEADBEEF;
      endcase
      m_sdata_out <= v;
      trace.push_back('{1'b0, m_saddress, v});
    end
    if ((m_swr && m_srd) || ((m_swr || m_srd) && prev_stb)) viol++;
    if ((m_swr || m_srd) && (m_saddress != prev_addr || m_sdata_in != prev_data)) viol++;
    prev_stb  = m_swr | m_srd;
    prev_addr = m_saddress;
    prev_data = m_sdata_in;
    if (n_reset) begin
      if (req0_valid && req0_ready) begin
        p = 64'(req0_a) * 64'(req0_b);
        e = timeout_mode ? '{1'b0, 32'h0, 32'h0, 1'b1} : '{1'b0, p[31:0], p[63:32], 1'b0};
        sb.push_back(e); grant_q.push_back(0); gcyc_q.push_back(cyc);
      end
      if (req1_valid && req1_ready) begin
        p = 64'(req1_a) * 64'(req1_b);
        e = timeout_mode ? '{1'b1, 32'h0, 32'h0, 1'b1} : '{1'b1, p[31:0], p[63:32], 1'b0};
        sb.push_back(e); grant_q.push_back(1); gcyc_q.push_back(cyc);
      end
      if (rsp_valid && rsp_ready) begin
        chk("sb_nonempty", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("sb_rsp", {rsp_id, rsp_err, rsp_w, rsp_l[29:0]}, {e.id, e.err, e.w, e.l[29:0]});
          chk("sb_rsp_l", 64'(rsp_l), 64'(e.l));
        end
      end
    end
  end

  task automatic job(input bit id, input logic [23:0] a, input logic [23:0] b, input bit hold,
                     output int lat, output logic [31:0] w, output logic [31:0] l,
                     output logic e, output logic rid);
    int n;
    int acc;
    @(negedge clk);
    if (id) begin req1_a = a; req1_b = b; req1_valid = 1'b1; end
    else    begin req0_a = a; req0_b = b; req0_valid = 1'b1; end
    #1;
    n = 0;
    while (!(id ? req1_ready : req0_ready) && n < 200) begin
      @(negedge clk); #1; n++;
    end
    chk("accept_bound", 64'(n < 200), 64'd1);
    @(posedge clk); #1;
    acc = cyc;
    req0_valid = 1'b0; req1_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 500) begin
      @(negedge clk); n++;
    end
    chk("rsp_bound", 64'(rsp_valid), 64'd1);
    lat = cyc - acc;
    w = rsp_w; l = rsp_l; e = rsp_err; rid = rsp_id;
    if (!hold) begin @(posedge clk); #1; end
  endtask

  int lat, n, cnt_st, cnt_wl, bad;
  logic [31:0] w, l, w0, l0;
  logic e, rid;
  op_t exp_ops[5];

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_addr", 64'(m_saddress), 64'h0);
    chk("rst_strobes", 64'({m_swr, m_srd}), 64'd0);
    chk("rst_sdata", 64'(m_sdata_in), 64'h0);
    chk("rst_rsp", 64'({rsp_id, rsp_err, rsp_w[15:0], rsp_l[15:0]}), 64'h0);
    @(negedge clk); n_reset = 1'b1;
    #1;
    chk("idle_ready", 64'({req0_ready, req1_ready}), 64'd0);

    // Basic job, first status read zero.
    trace.delete(); busy_left = 0;
    job(0, 24'd2, 24'd7, 0, lat, w, l, e, rid);
    chk("lat13", 64'(lat), 64'd13);
    chk("w_2x7", 64'(w), 64'hE);
    chk("id0", 64'(rid), 64'd0);
    exp_ops[0] = '{1'b1, 16'h108, 32'd2};
    exp_ops[1] = '{1'b1, 16'h110, 32'd7};
    exp_ops[2] = '{1'b0, 16'h128, 32'd0};
    exp_ops[3] = '{1'b0, 16'h118, 32'hE};
    exp_ops[4] = '{1'b0, 16'h120, 32'd0};
    chk("trace_len", 64'(trace.size()), 64'd5);
    for (int i = 0; i < 5 && i < trace.size(); i++)
      chk($sformatf("trace%0d", i), {15'd0, trace[i].wr, trace[i].addr, trace[i].data},
          {15'd0, exp_ops[i].wr, exp_ops[i].addr, exp_ops[i].data});

    job(1, 24'hED, 24'hFA, 0, lat, w, l, e, rid);
    chk("w_ed_fa", 64'({w, l}), 64'h0000E772_00000000);
    chk("err_ed_fa", 64'({e, rid}), 64'b01);

    trace.delete();
    job(1, 24'hFFFFFF, 24'hFFFFFF, 0, lat, w, l, e, rid);
    chk("w_max", 64'(w), 64'hFE000001);
    chk("l_max", 64'(l), 64'h0000FFFF);
    chk("wr_a_max", 64'(trace[0].data), 64'h00FFFFFF);
    chk("wr_b_max", 64'(trace[1].data), 64'h00FFFFFF);

    // Both requesters valid continuously.
    grant_q.delete(); gcyc_q.delete();
    @(negedge clk);
    req0_a = 3; req0_b = 5; req1_a = 6; req1_b = 7;
    req0_valid = 1'b1; req1_valid = 1'b1;
    n = 0;
    while (grant_q.size() < 4 && n < 300) begin @(negedge clk); #3; n++; end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    n = 0;
    while (busy && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    chk("grant_cnt", 64'(grant_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < grant_q.size(); i++)
      chk($sformatf("grant%0d", i), 64'(grant_q[i]), 64'(i % 2));
    for (int i = 1; i < 4 && i < gcyc_q.size(); i++)
      chk($sformatf("gap%0d", i), 64'(gcyc_q[i] - gcyc_q[i-1] >= 14), 64'd1);

    // Three busy status reads before ready.
    trace.delete(); busy_left = 3;
    job(0, 24'd9, 24'd11, 0, lat, w, l, e, rid);
    cnt_st = 0;
    foreach (trace[i]) if (!trace[i].wr && trace[i].addr == 16'h128) cnt_st++;
    chk("polls4", 64'(cnt_st), 64'd4);
    chk("lat22", 64'(lat), 64'd22);
    chk("w_9x11", 64'(w), 64'd99);

    // Consumer stalls the response.
    rsp_ready = 1'b0;
    job(1, 24'd12, 24'd13, 1, lat, w0, l0, e, rid);
    req0_a = 1; req0_b = 1; req0_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (!rsp_valid || rsp_w != w0 || rsp_l != l0 || rsp_id != 1'b1 || req0_ready) bad++;
    end
    chk("hold_stable", 64'(bad), 64'd0);
    chk("hold_w", 64'(w0), 64'd156);
    req0_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("hold_release", 64'(busy), 64'd0);

`ifdef POLL_TIMEOUT_EN
    trace.delete(); stuck = 1; timeout_mode = 1;
    job(0, 24'd5, 24'd6, 0, lat, w, l, e, rid);
    stuck = 0; timeout_mode = 0;
    cnt_st = 0; cnt_wl = 0;
    foreach (trace[i]) begin
      if (!trace[i].wr && trace[i].addr == 16'h128) cnt_st++;
      if (!trace[i].wr && (trace[i].addr == 16'h118 || trace[i].addr == 16'h120)) cnt_wl++;
    end
    chk("to_polls", 64'(cnt_st), 64'd4);
    chk("to_wl", 64'(cnt_wl), 64'd0);
    chk("to_err", 64'({e, w, l[0]}), {31'd0, 1'b1, 32'd0, 1'b0});
`endif

    // Reset arriving while polling.
    stuck = 1;
    @(negedge clk);
    req0_a = 4; req0_b = 4; req0_valid = 1'b1;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); #1; n++; end
    while (!(m_srd && m_saddress == 16'h128) && n < 100);
    chk("poll_seen", 64'(n < 100), 64'd1);
    n_reset = 1'b0;
    #1;
    chk("rst_mid_strobes", 64'({m_srd, m_swr}), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    sb.delete();
    @(negedge clk); n_reset = 1'b1; stuck = 0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (rsp_valid || busy) bad++;
    end
    chk("rst_mid_idle", 64'(bad), 64'd0);

    chk("protocol", 64'(viol), 64'd0);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_job_sequencer.md
Name: mul_job_sequencer

Overview:
- Bus-master sequencer that shares the gpioemu multiplier peripheral between two job requesters.
- For each job it:
  - writes operand A to 0x108 and operand B to 0x110;
  - polls status B at 0x128 until it reads zero;
  - reads result W at 0x118 and secondary result L at 0x120.
- It then returns W and L to the granted requester.
- Sits between software-facing job ports and the gpioemu saddress/srd/swr/sdata bus.

Parameters:
- OPERAND_W, 24, operand width; operands are zero-extended to 32 bits on the bus.
- POLL_LIMIT, 255, maximum status polls before timeout (used only with POLL_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- n_reset  in  1  reset, asynchronous, active-low.
- req0_valid  in  1  requester 0 has a job.
- req0_ready  out  1  requester 0 job accepted this cycle.
- req0_a  in  OPERAND_W  requester 0 operand A.
- req0_b  in  OPERAND_W  requester 0 operand B.
- req1_valid, req1_ready, req1_a, req1_b: same as requester 0, for requester 1.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer takes the response.
- rsp_id  out  1  index of the requester that owns the response.
- rsp_w  out  32  W register value.
- rsp_l  out  32  L register value.
- rsp_err  out  1  job ended by poll timeout.
- m_saddress  out  16  peripheral address.
- m_swr  out  1  write strobe.
- m_srd  out  1  read strobe.
- m_sdata_in  out  32  write data to peripheral.
- m_sdata_out  in  32  read data from peripheral.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values (all outputs): 0, except m_saddress = 0x0000. last_grant = 1, so requester 0 wins the first tie.
- Reset is asynchronous and may arrive mid-job. Strobes drop immediately, the job is discarded, no response is issued and the FSM returns to IDLE.
- Arbitration happens only in IDLE; reqN_ready is combinational and only one ready is ever high.
  - Only one requester valid: it is granted.
  - Both valid: the requester other than last_grant is granted.
  - Accept occurs on valid & ready. Operands and id are latched on that edge and last_grant is updated.
- Bus transactions are issued through the bus_txn sub-module:
  - Write: 2 cycles. SETUP drives address and data with strobes low; STB holds them with m_swr = 1.
  - Read: 3 cycles. SETUP, then STB with m_srd = 1, then CAP samples m_sdata_out with the strobe low.
  - Address and data stay stable from SETUP through the end of the transaction.
  - m_swr and m_srd are never high together and never high for 2 consecutive cycles.
- FSM states: IDLE, WR_A, WR_B, POLL, RD_W, RD_L, RESP. Sequence per job:
  - IDLE to WR_A on accept.
  - WR_A (0x108, zero-extended A) to WR_B.
  - WR_B (0x110) to POLL.
  - POLL (read 0x128): result 0 goes to RD_W; nonzero re-polls immediately.
  - RD_W (0x118) to RD_L.
  - RD_L (0x120) to RESP.
- Latency: rsp_valid rises 13 cycles after the accept edge when the first poll reads 0. Each extra poll adds 3 cycles.
- RESP:
  - rsp_valid = 1 with rsp_id, rsp_w, rsp_l held stable until rsp_ready.
  - On valid & ready, go to IDLE; the next job can be accepted on the following cycle.
  - No new job is accepted while in RESP.
- Operand bits above OPERAND_W are zero. The block does no arithmetic; W and L are passed through unmodified.

Optional Feature:
- POLL_TIMEOUT_EN defined:
  - An 8-bit poll counter clears at WR_A.
  - When POLL_LIMIT consecutive polls read nonzero, the FSM skips RD_W/RD_L and goes to RESP with rsp_err = 1, rsp_w = 0, rsp_l = 0.
- Undefined:
  - Polling continues indefinitely; the counter logic is absent and rsp_err is tied to 0.

Decomposition:
- Package mul_seq_pkg holds:
  - address constants ADDR_A1 = 16'h108, ADDR_A2 = 16'h110, ADDR_W = 16'h118, ADDR_L = 16'h120, ADDR_B = 16'h128;
  - the FSM state enum;
  - the bus_txn phase enum (SETUP/STB/CAP).
- One sub-module, bus_txn:
  - inputs: start, is_read, addr, wdata;
  - outputs: done, rdata, and the m_* bus signals.
- The top level keeps arbitration, the job FSM, and the response registers.

Test Plan:
- Req0 A=2, B=7, slave model B reads 0 → bus trace wr 0x108=2, wr 0x110=7, rd 0x128, rd 0x118, rd 0x120; rsp_w=0xE, rsp_id=0; rsp_valid exactly 13 cycles after accept.
- Req1 A=0xED, B=0xFA → rsp_w=0xE772, rsp_l=0, rsp_err=0. Then A=0xFFFFFF, B=0xFFFFFF → m_sdata_in=0x00FFFFFF on both writes; rsp_w=0xFE000001.
- Both requesters valid continuously → grants alternate 0,1,0,1, with no two accepts less than 14 cycles apart.
- Slave B reads nonzero 3 times then 0 → 4 status reads; rsp_valid delayed by 9 cycles versus the first scenario.
- Hold rsp_ready=0 for 10 cycles → rsp_* stable and no new accept; assert n_reset=0 mid-POLL → strobes low in the same cycle, then IDLE, no rsp_valid.
- With POLL_TIMEOUT_EN, POLL_LIMIT=4, and B stuck at 1 → exactly 4 status reads, no W/L reads, rsp_err=1, rsp_w=0.
